// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_rx
// Brief    : PS/2 keyboard frame receiver with scan-code FIFO and 16-bit
//            status/data word. Define PS2_PARITY_CHECK_EN to enable odd-parity
//            checking.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        rd_en,
    output logic [15:0] xkey
);

    localparam int               c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               c_WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);
    localparam logic [3:0]       c_DEPTH   = 4'(FIFO_DEPTH);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
    localparam logic [1:0] c_ST_PARITY = 2'd2;
    localparam logic [1:0] c_ST_STOP   = 2'd3;

    logic               r_clk_s1, r_clk_s2, r_clk_s3;
    logic               r_dat_s1, r_dat_s2;
    logic               w_fall;
    logic [1:0]         r_state;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic [c_WD_W-1:0]  r_wdog;
    logic               r_acc_v;
    logic [7:0]         r_acc_code;
    logic               r_rej;
    logic               w_par_ok;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [3:0]         r_count;
    logic               r_ovf, r_err;
    logic               w_valid, w_pop, w_full, w_wr_en, w_drop;

    // Idle PS/2 lines are high, so the synchronizers reset to 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_s3 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_s3 & ~r_clk_s2;

`ifdef PS2_PARITY_CHECK_EN
    logic r_par;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par <= 1'b0;
        end else if (w_fall && r_state == c_ST_PARITY) begin
            r_par <= r_dat_s2;
        end
    end

    assign w_par_ok = ^{r_shift, r_par};
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_wdog     <= '0;
            r_acc_v    <= 1'b0;
            r_acc_code <= 8'h00;
            r_rej      <= 1'b0;
        end else begin
            r_acc_v <= 1'b0;
            r_rej   <= 1'b0;
            if (w_fall) begin
                r_wdog <= '0;
                case (r_state)
                    c_ST_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state   <= c_ST_DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    c_ST_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= c_ST_PARITY;
                        end
                    end
                    c_ST_PARITY: begin
                        r_state <= c_ST_STOP;
                    end
                    default: begin
                        if (r_dat_s2 && w_par_ok) begin
                            r_acc_v    <= 1'b1;
                            r_acc_code <= r_shift;
                        end else begin
                            r_rej <= 1'b1;
                        end
                        r_state <= c_ST_IDLE;
                        r_shift <= 8'h00;
                    end
                endcase
            end else if (r_state != c_ST_IDLE) begin
                // A stalled keyboard abandons the partial frame silently.
                if (r_wdog == c_WD_LAST) begin
                    r_state   <= c_ST_IDLE;
                    r_shift   <= 8'h00;
                    r_bit_cnt <= 3'd0;
                    r_wdog    <= '0;
                end else begin
                    r_wdog <= r_wdog + c_WD_W'(1);
                end
            end
        end
    end

    assign w_valid = (r_count != 4'd0);
    assign w_full  = (r_count == c_DEPTH);
    assign w_pop   = rd_en & w_valid;
    assign w_wr_en = r_acc_v & (~w_full | w_pop);
    assign w_drop  = r_acc_v & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= r_acc_code;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 4'd0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_wr_en && !w_pop) begin
                r_count <= r_count + 4'd1;
            end else if (w_pop && !w_wr_en) begin
                r_count <= r_count - 4'd1;
            end
            // A set event in the same cycle as a read takes priority.
            r_ovf <= w_drop | (r_ovf & ~rd_en);
            r_err <= r_rej  | (r_err & ~rd_en);
        end
    end

    assign xkey = {w_valid, r_ovf, r_err, 1'b0, r_count,
                   w_valid ? r_mem[r_rd_ptr] : 8'h00};

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbd_rx
// Brief    : Self-checking bench for ps2_kbd_rx against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_rx;

    localparam int DEPTH   = 8;
    localparam int TMO     = 200;
    localparam int HALF    = 20;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN  = 1'b1;
`else
    localparam bit PAR_EN  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic        rd_en;
    logic [15:0] xkey;

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];
    bit         m_ovf;
    bit         m_err;

    ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rd_en    (rd_en),
        .xkey     (xkey)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] exp_xkey();
        logic [7:0] head;
        head = (q.size() != 0) ? q[0] : 8'h00;
        return {q.size() != 0, m_ovf, m_err, 1'b0, 4'(q.size()), head};
    endfunction

    function automatic logic good_par(input logic [7:0] code);
        return ~^code;
    endfunction

    function automatic void model_frame(input logic [7:0] code, input logic par,
                                        input logic stop, input bit rd);
        bit full;
        bit popped;
        bit accept;
        full   = (q.size() == DEPTH);
        popped = rd && (q.size() != 0);
        accept = stop && (!PAR_EN || (par == good_par(code)));
        if (rd) begin
            if (popped) void'(q.pop_front());
            m_ovf = 1'b0;
            m_err = 1'b0;
        end
        if (accept) begin
            if (full && !popped) m_ovf = 1'b1;
            else q.push_back(code);
        end else begin
            m_err = 1'b1;
        end
    endfunction

    function automatic void model_read();
        if (q.size() != 0) void'(q.pop_front());
        m_ovf = 1'b0;
        m_err = 1'b0;
    endfunction

    task automatic ps2_bit(input logic b);
        @(posedge clk); #1 ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    // rd_at_push lines rd_en up with the cycle the FIFO write lands.
    task automatic send_frame(input logic [7:0] code, input logic par,
                              input logic stop, input bit rd_at_push);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit(par);
        @(posedge clk); #1 ps2_data = stop;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        if (rd_at_push) begin
            repeat (3) @(posedge clk);
            #1 rd_en = 1'b1;
            @(posedge clk);
            #1 rd_en = 1'b0;
            repeat (HALF - 4) @(posedge clk);
        end else begin
            repeat (HALF) @(posedge clk);
        end
        #1 ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        model_frame(code, par, stop, rd_at_push);
    endtask

    task automatic do_read();
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
        model_read();
    endtask

    task automatic test_reset();
        total++;
        if (xkey !== 16'h0000) begin
            $display("FAIL reset_state xkey=%h expected=%h", xkey, 16'h0000);
            bad++;
        end
    endtask

    task automatic test_single();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        total++;
        if (xkey !== 16'h811C || xkey !== exp_xkey()) begin
            $display("FAIL single_push xkey=%h expected=%h", xkey, 16'h811C);
            bad++;
        end
        do_read();
        total++;
        if (xkey !== 16'h0000) begin
            $display("FAIL single_pop xkey=%h expected=%h", xkey, 16'h0000);
            bad++;
        end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [9];
        codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
        for (int i = 0; i < 9; i++) send_frame(codes[i], good_par(codes[i]), 1'b1, 1'b0);
        total++;
        if (xkey !== 16'hC81C || xkey !== exp_xkey()) begin
            $display("FAIL overflow_full xkey=%h expected=%h", xkey, 16'hC81C);
            bad++;
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (xkey[7:0] !== codes[i]) begin
                $display("FAIL overflow_order[%0d] code=%h expected=%h", i, xkey[7:0], codes[i]);
                bad++;
            end
            do_read();
        end
        total++;
        if (xkey !== 16'h0000) begin
            $display("FAIL overflow_drained xkey=%h expected=%h", xkey, 16'h0000);
            bad++;
        end
    endtask

    task automatic test_parity();
        logic [15:0] want;
        want = PAR_EN ? 16'h2000 : 16'h811C;
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        total++;
        if (xkey !== want || xkey !== exp_xkey()) begin
            $display("FAIL parity_error xkey=%h expected=%h", xkey, want);
            bad++;
        end
        send_frame(8'h44, good_par(8'h44), 1'b0, 1'b0);
        total++;
        if (xkey[13] !== 1'b1 || xkey !== exp_xkey()) begin
            $display("FAIL stop_error xkey=%h expected=%h", xkey, exp_xkey());
            bad++;
        end
        while (q.size() != 0 || m_err || m_ovf) do_read();
        total++;
        if (xkey !== 16'h0000) begin
            $display("FAIL parity_clear xkey=%h expected=%h", xkey, 16'h0000);
            bad++;
        end
    endtask

    task automatic test_timeout();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
        repeat (TMO + 6) @(posedge clk);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        total++;
        if (xkey !== 16'h815A || xkey !== exp_xkey()) begin
            $display("FAIL timeout_recover xkey=%h expected=%h", xkey, 16'h815A);
            bad++;
        end
        do_read();
    endtask

    task automatic test_simultaneous();
        logic [7:0] codes [9];
        for (int i = 0; i < 9; i++) codes[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) send_frame(codes[i], good_par(codes[i]), 1'b1, 1'b0);
        send_frame(codes[8], good_par(codes[8]), 1'b1, 1'b1);
        total++;
        if (xkey[15:8] !== 8'h88 || xkey !== exp_xkey()) begin
            $display("FAIL simul_count xkey=%h expected=%h", xkey, exp_xkey());
            bad++;
        end
        for (int i = 1; i < 9; i++) begin
            total++;
            if (xkey !== exp_xkey() || xkey[7:0] !== codes[i]) begin
                $display("FAIL simul_order[%0d] xkey=%h expected code=%h", i, xkey, codes[i]);
                bad++;
            end
            do_read();
        end
        total++;
        if (xkey !== 16'h0000) begin
            $display("FAIL simul_drained xkey=%h expected=%h", xkey, 16'h0000);
            bad++;
        end
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h11, good_par(8'h11), 1'b1, 1'b0);
        total++;
        if (xkey !== 16'h8111) begin
            $display("FAIL pre_reset xkey=%h expected=%h", xkey, 16'h8111);
            bad++;
        end
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b0);
        @(posedge clk); #1 ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        total++;
        if (xkey !== 16'h0000) begin
            $display("FAIL async_reset xkey=%h expected=%h", xkey, 16'h0000);
            bad++;
        end
        q.delete();
        m_ovf = 1'b0;
        m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 ps2_clk = 1'b1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        total++;
        if (xkey !== 16'h81F0 || xkey !== exp_xkey()) begin
            $display("FAIL post_reset xkey=%h expected=%h", xkey, 16'h81F0);
            bad++;
        end
        do_read();
    endtask

    task automatic test_random();
        logic [7:0] code;
        logic       par;
        logic       stop;
        int         kind;
        for (int n = 0; n < 24; n++) begin
            code = 8'($urandom);
            kind = $urandom_range(0, 5);
            par  = good_par(code) ^ (kind == 0);
            stop = (kind != 1);
            send_frame(code, par, stop, 1'b0);
            total++;
            if (xkey !== exp_xkey()) begin
                $display("FAIL random_frame[%0d] xkey=%h expected=%h", n, xkey, exp_xkey());
                bad++;
            end
            if ($urandom_range(0, 2) == 0) begin
                do_read();
                total++;
                if (xkey !== exp_xkey()) begin
                    $display("FAIL random_read[%0d] xkey=%h expected=%h", n, xkey, exp_xkey());
                    bad++;
                end
            end
        end
        while (q.size() != 0 || m_err || m_ovf) do_read();
        total++;
        if (xkey !== 16'h0000) begin
            $display("FAIL random_drained xkey=%h expected=%h", xkey, 16'h0000);
            bad++;
        end
    endtask

    initial begin
        rst      = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rd_en    = 1'b0;
        m_ovf    = 1'b0;
        m_err    = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_overflow();
        test_parity();
        test_timeout();
        test_simultaneous();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
